step_pulse_gen: RTL and testbench

//  Upstream of the processor/memory top level: turns a raw board button (bouncy, async) into a clean
//  one-cycle step enable on the 50 MHz board clock, replacing the switch-driven processor clock.

---
 rtl/step_pulse_gen.sv | 44 ++++
 tb/tb_step_pulse_gen.sv | 132 +++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: debounced button / auto-divider single-cycle step enable with a step counter
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_DIV        = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        btn_in,
  input  logic        auto_en,
  output logic        step_en,
  output logic        btn_level,
  output logic [15:0] step_count
);
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(AUTO_DIV - 1);
  logic             r_s1, r_s2;
  logic [CNT_W-1:0] r_db_cnt, r_div_cnt;
  logic             w_db_diff, w_db_done, w_rise, w_div_hit;
  assign w_db_diff = r_s2 != btn_level;
  assign w_db_done = w_db_diff && r_db_cnt == DB_MAX;
  // only a 0->1 acceptance is a press; releases are tracked but never pulse
  assign w_rise    = w_db_done && r_s2;
  assign w_div_hit = auto_en && r_div_cnt == DIV_MAX;
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_db_cnt   <= '0;
      r_div_cnt  <= '0;
      btn_level  <= 1'b0;
      step_en    <= 1'b0;
      step_count <= '0;
    end else begin
      r_s1       <= btn_in;
      r_s2       <= r_s1;
      r_db_cnt   <= (w_db_diff && !w_db_done) ? r_db_cnt + CNT_W'(1) : '0;
      btn_level  <= w_db_done ? r_s2 : btn_level;
      r_div_cnt  <= (auto_en && !w_div_hit) ? r_div_cnt + CNT_W'(1) : '0;
      step_en    <= auto_en ? w_div_hit : w_rise;
      step_count <= step_count + {15'd0, step_en};
    end
  end
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: table vectors, directed corner sequences and random stimulus vs a behavioural model
module tb_step_pulse_gen;
  localparam int DEB  = 4;
  localparam int ADIV = 5;
  logic        clk = 0, rst = 1, btn = 0, aen = 0;
  logic        step, level;
  logic [15:0] cnt;
  int checks = 0, errors = 0, pulses = 0;
  bit m_s1, m_s2, m_level, m_step;
  int m_run, m_arun, m_cnt;
  typedef struct {
    logic r, b, a;
    logic lv, st;
    int   c;
  } vec_t;
  vec_t tv[17];

  always #5 clk = ~clk;

  step_pulse_gen #(.DEBOUNCE_CYCLES(DEB), .AUTO_DIV(ADIV), .CNT_W(4)) dut (
    .Clock(clk), .reset(rst), .btn_in(btn), .auto_en(aen),
    .step_en(step), .btn_level(level), .step_count(cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: level flips once s2 has disagreed for DEB consecutive edges;
  // auto pulses whenever the run of auto_en-high edges is a multiple of ADIV.
  task automatic tick();
    bit flip, rise, apulse;
    @(posedge clk);
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_step = 0;
      m_run = 0; m_arun = 0; m_cnt = 0;
    end else begin
      m_run  = (m_s2 != m_level) ? m_run + 1 : 0;
      flip   = m_run == DEB;
      rise   = flip && m_s2;
      if (flip) begin m_level = m_s2; m_run = 0; end
      m_s2   = m_s1;
      m_s1   = btn;
      m_arun = aen ? m_arun + 1 : 0;
      apulse = aen && m_arun % ADIV == 0;
      m_cnt  = (m_cnt + int'(m_step)) % 65536;
      m_step = aen ? apulse : rise;
    end
    #1;
    if (step) pulses++;
    chk("model_level", int'(level), int'(m_level));
    chk("model_step", int'(step), int'(m_step));
    chk("model_count", int'(cnt), m_cnt);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first;
    // reset held 3 cycles with button pressed, then released reset; later the button is released
    for (int i = 0; i < 17; i++) tv[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    for (int i = 0; i < 3; i++) tv[i].r = 1'b1;
    tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tv[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    for (int i = 11; i < 16; i++) tv[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tv[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    for (int i = 0; i < 17; i++) begin
      rst = tv[i].r; btn = tv[i].b; aen = tv[i].a;
      tick();
      chk($sformatf("vec%0d_level", i), int'(level), int'(tv[i].lv));
      chk($sformatf("vec%0d_step", i), int'(step), int'(tv[i].st));
      chk($sformatf("vec%0d_count", i), int'(cnt), tv[i].c);
    end
    ticks(5);
    // bounce 1,0,1,1,0 then steady 1: exactly one pulse, level 1
    pulses = 0;
    foreach (tv[i]) if (i < 5) begin btn = (i == 0 || i == 2 || i == 3); tick(); end
    btn = 1;
    ticks(3);
    chk("bounce_level_early", int'(level), 0);
    ticks(12);
    chk("bounce_level", int'(level), 1);
    chk("bounce_pulses", pulses, 1);
    // hold 50 cycles total, then release: still one pulse, level returns to 0
    ticks(35);
    btn = 0;
    ticks(10);
    chk("hold_pulses", pulses, 1);
    chk("release_level", int'(level), 0);
    chk("hold_count", int'(cnt), 2);
    // auto mode 26 cycles: pulses at 5,10,15,20,25
    pulses = 0; first = 0; aen = 1;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (step && first == 0) first = k;
    end
    chk("auto_first", first, ADIV);
    chk("auto_pulses", pulses, 5);
    aen = 0; ticks(3);
    // auto dropped at cycle 23: the 5th pulse never appears
    pulses = 0; aen = 1;
    ticks(23);
    aen = 0;
    ticks(8);
    chk("auto_drop_pulses", pulses, 4);
    chk("auto_count", int'(cnt), 11);
    // reset in the middle of an auto count
    aen = 1; ticks(3);
    rst = 1; tick();
    chk("midrst_step", int'(step), 0);
    chk("midrst_count", int'(cnt), 0);
    rst = 0; tick();
    chk("postrst_step", int'(step), 0);
    aen = 0; ticks(2);
    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) btn = ~btn;
      if ($urandom_range(39) == 0) aen = ~aen;
      rst = $urandom_range(299) == 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
